// File: rtl/fft16_stage_ctrl.sv
`default_nettype none
// ============================================================================
// fft16_stage_ctrl : stage/butterfly sequencer for a radix-2 DIT FFT with
//                    in-place addressing, twiddle indexing and a watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module fft16_stage_ctrl #(
  parameter int LOG2N      = 4,
  parameter int BF_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_bf_done,
  output logic             o_bf_start,
  output logic [LOG2N-1:0] o_rd_addr0,
  output logic [LOG2N-1:0] o_rd_addr1,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr0,
  output logic [LOG2N-1:0] o_wr_addr1,
  output logic [1:0]       o_stage,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]       c_LAST_S  = 2'(LOG2N-1);
  localparam logic [LOG2N-2:0] c_LAST_K  = '1;
  localparam logic [LOG2N-2:0] c_K_ONE   = (LOG2N-1)'(1);
  localparam logic [LOG2N-1:0] c_A_ONE   = LOG2N'(1);
  localparam logic [8:0]       c_TIMEOUT = 9'(BF_TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_s, w_s_nxt;
  logic [LOG2N-2:0] r_k, w_k_nxt;
  logic [7:0]       r_w, w_w_nxt;
  logic             r_error, w_error_nxt;
  logic             r_addr_vld, w_addr_vld_nxt;
  logic [8:0]       w_w_inc;
  logic [LOG2N-1:0] w_half, w_kx, w_j, w_g, w_addr0, w_addr1;
  logic [LOG2N-2:0] w_tw;

  assign w_w_inc = {1'b0, r_w} + 9'd1;

  // half = 2^s, j = k mod half, g = k / half; operands sit g*2*half + j apart by half
  assign w_half  = c_A_ONE << r_s;
  assign w_kx    = {1'b0, r_k};
  assign w_j     = w_kx & (w_half - c_A_ONE);
  assign w_g     = w_kx >> r_s;
  assign w_addr0 = (w_g << ({1'b0, r_s} + 3'd1)) | w_j;
  assign w_addr1 = w_addr0 | w_half;
  assign w_tw    = w_j[LOG2N-2:0] << (c_LAST_S - r_s);

  // Addresses read as zero until the first accepted start after reset
  assign o_rd_addr0 = r_addr_vld ? w_addr0 : '0;
  assign o_rd_addr1 = r_addr_vld ? w_addr1 : '0;
  assign o_wr_addr0 = o_rd_addr0;
  assign o_wr_addr1 = o_rd_addr1;
  assign o_tw_idx   = r_addr_vld ? w_tw : '0;
  assign o_stage    = r_s;
  assign o_error    = r_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_s        <= '0;
      r_k        <= '0;
      r_w        <= '0;
      r_error    <= 1'b0;
      r_addr_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_k        <= w_k_nxt;
      r_w        <= w_w_nxt;
      r_error    <= w_error_nxt;
      r_addr_vld <= w_addr_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_k_nxt        = r_k;
    w_w_nxt        = r_w;
    w_error_nxt    = r_error;
    w_addr_vld_nxt = r_addr_vld;
    o_bf_start     = 1'b0;
    o_wr_en        = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_START;
          w_s_nxt        = '0;
          w_k_nxt        = '0;
          w_w_nxt        = '0;
          w_error_nxt    = 1'b0;
          w_addr_vld_nxt = 1'b1;
        end
      end
      S_START: begin
        o_bf_start  = 1'b1;
        o_busy      = 1'b1;
        w_w_nxt     = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (i_bf_done) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_w_nxt = w_w_inc[7:0];
          if (w_w_inc == c_TIMEOUT) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
          end
        end
      end
      S_WRITE: begin
        o_wr_en = 1'b1;
        o_busy  = 1'b1;
        if (r_s == c_LAST_S && r_k == c_LAST_K) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt = r_k + c_K_ONE;
          if (r_k == c_LAST_K) w_s_nxt = r_s + 2'd1;
          w_state_nxt = S_START;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fft16_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fft16_stage_ctrl : directed self-checking bench for fft16_stage_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft16_stage_ctrl;

  logic clk = 1'b0;
  logic rst, start, bf_done, sel_wd;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic       d_bf_start, d_wr_en, d_busy, d_done, d_error;
  logic [3:0] d_rd0, d_rd1, d_wr0, d_wr1;
  logic [2:0] d_tw;
  logic [1:0] d_stage;
  logic       x_bf_start, x_wr_en, x_busy, x_done, x_error;
  logic [3:0] x_rd0, x_rd1, x_wr0, x_wr1;
  logic [2:0] x_tw;
  logic [1:0] x_stage;

  fft16_stage_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bf_done(bf_done),
    .o_bf_start(d_bf_start), .o_rd_addr0(d_rd0), .o_rd_addr1(d_rd1),
    .o_tw_idx(d_tw), .o_wr_en(d_wr_en), .o_wr_addr0(d_wr0), .o_wr_addr1(d_wr1),
    .o_stage(d_stage), .o_busy(d_busy), .o_done(d_done), .o_error(d_error)
  );

  fft16_stage_ctrl #(.BF_TIMEOUT(10)) u_dut_wd (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bf_done(bf_done),
    .o_bf_start(x_bf_start), .o_rd_addr0(x_rd0), .o_rd_addr1(x_rd1),
    .o_tw_idx(x_tw), .o_wr_en(x_wr_en), .o_wr_addr0(x_wr0), .o_wr_addr1(x_wr1),
    .o_stage(x_stage), .o_busy(x_busy), .o_done(x_done), .o_error(x_error)
  );

  logic       m_bf_start, m_wr_en, m_busy, m_done, m_error;
  logic [3:0] m_rd0, m_rd1, m_wr0, m_wr1;
  logic [2:0] m_tw;
  logic [1:0] m_stage;

  assign m_bf_start = sel_wd ? x_bf_start : d_bf_start;
  assign m_wr_en    = sel_wd ? x_wr_en    : d_wr_en;
  assign m_busy     = sel_wd ? x_busy     : d_busy;
  assign m_done     = sel_wd ? x_done     : d_done;
  assign m_error    = sel_wd ? x_error    : d_error;
  assign m_rd0      = sel_wd ? x_rd0      : d_rd0;
  assign m_rd1      = sel_wd ? x_rd1      : d_rd1;
  assign m_wr0      = sel_wd ? x_wr0      : d_wr0;
  assign m_wr1      = sel_wd ? x_wr1      : d_wr1;
  assign m_tw       = sel_wd ? x_tw       : d_tw;
  assign m_stage    = sel_wd ? x_stage    : d_stage;

  // Hand-computed (addr0, addr1, tw) for selected butterflies n = s*8 + k
  logic [3:0] ea0 [32];
  logic [3:0] ea1 [32];
  logic [2:0] etw [32];
  bit         ev  [32];

  task automatic set_exp(input int n, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [2:0] tw);
    ea0[n] = a0; ea1[n] = a1; etw[n] = tw; ev[n] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bf_start"}, m_bf_start, 0);
    chk({tag, "_rd0"},      m_rd0, 0);
    chk({tag, "_rd1"},      m_rd1, 0);
    chk({tag, "_wr0"},      m_wr0, 0);
    chk({tag, "_wr1"},      m_wr1, 0);
    chk({tag, "_tw"},       m_tw, 0);
    chk({tag, "_wr_en"},    m_wr_en, 0);
    chk({tag, "_stage"},    m_stage, 0);
    chk({tag, "_busy"},     m_busy, 0);
    chk({tag, "_done"},     m_done, 0);
    chk({tag, "_error"},    m_error, 0);
  endtask

  // Entered in cycle 1 (the START of butterfly 0); leaves in cycle 97 (DONE)
  task automatic run_min(input bit poke);
    int wr;
    wr = 0;
    bf_done = 1'b1;
    for (int c = 1; c <= 97; c++) begin
      if (poke) start = (c == 10 || c == 97);
      chk("min_bf_start", m_bf_start, (c <= 96 && c % 3 == 1));
      chk("min_wr_en",    m_wr_en,    (c <= 96 && c % 3 == 0));
      chk("min_busy",     m_busy,     (c <= 96));
      chk("min_done",     m_done,     (c == 97));
      if (m_wr_en) begin
        if (wr < 32 && ev[wr]) begin
          chk("addr0",    m_rd0, ea0[wr]);
          chk("addr1",    m_rd1, ea1[wr]);
          chk("tw",       m_tw,  etw[wr]);
          chk("wr_addr0", m_wr0, ea0[wr]);
          chk("wr_addr1", m_wr1, ea1[wr]);
          chk("stage",    m_stage, wr / 8);
        end
        wr++;
      end
      if (c < 97) step();
    end
    chk("min_wr_count", wr, 32);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int dones, wrs, moves, lat, wr;
    logic [3:0] cap0, cap1;
    logic [2:0] captw;

    for (int n = 0; n < 32; n++) ev[n] = 1'b0;
    set_exp(0,  4'd0,  4'd1,  3'd0);
    set_exp(1,  4'd2,  4'd3,  3'd0);
    set_exp(7,  4'd14, 4'd15, 3'd0);
    set_exp(9,  4'd1,  4'd3,  3'd4);
    set_exp(10, 4'd4,  4'd6,  3'd0);
    set_exp(11, 4'd5,  4'd7,  3'd4);
    set_exp(19, 4'd3,  4'd7,  3'd6);
    set_exp(21, 4'd9,  4'd13, 3'd2);
    set_exp(24, 4'd0,  4'd8,  3'd0);
    set_exp(31, 4'd7,  4'd15, 3'd7);

    sel_wd = 1'b0; start = 1'b0; bf_done = 1'b0;
    do_reset();
    chk_zero("rst");

    // Minimum-latency transform with done tied high
    start = 1'b1; step(); start = 1'b0;
    run_min(1'b0);
    step();
    chk("idle_done",  m_done, 0);
    chk("idle_busy",  m_busy, 0);
    chk("hold_addr0", m_rd0, 7);
    chk("hold_addr1", m_rd1, 15);
    chk("hold_tw",    m_tw, 7);
    chk("hold_stage", m_stage, 3);

    // Variable latency with stale done asserted during every START
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    dones = 0; wrs = 0; moves = 0;
    for (int b = 0; b < 32; b++) begin
      chk("vl_start", m_bf_start, 1);
      cap0 = m_rd0; cap1 = m_rd1; captw = m_tw;
      lat = 1 + (b * 7) % 20;
      bf_done = 1'b1;
      for (int m = 1; m <= lat; m++) begin
        step();
        if (m == 1) chk("vl_stale", m_wr_en, 0);
        if (m_rd0 !== cap0 || m_rd1 !== cap1 || m_tw !== captw) moves++;
        if (m_wr_en) wrs++;
        if (m_done) dones++;
        bf_done = (m == lat);
      end
      step();
      chk("vl_wr",    m_wr_en, 1);
      chk("vl_addr0", m_rd0, cap0);
      chk("vl_addr1", m_rd1, cap1);
      chk("vl_tw",    m_tw, captw);
      if (m_wr_en) wrs++;
      bf_done = 1'b0;
      step();
    end
    chk("vl_done", m_done, 1);
    chk("vl_done_busy", m_busy, 0);
    if (m_done) dones++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m_done) dones++;
    end
    chk("vl_done_count", dones, 1);
    chk("vl_wr_count", wrs, 32);
    chk("vl_addr_moves", moves, 0);

    // Watchdog: butterfly (1,2) never answers, timeout of 10 WAIT cycles
    do_reset();
    sel_wd = 1'b1;
    bf_done = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    wr = 0;
    for (int c = 1; c <= 30; c++) begin
      if (m_wr_en) wr++;
      step();
    end
    chk("wd_pre_writes", wr, 10);
    chk("wd_bf_start", m_bf_start, 1);
    chk("wd_addr0", m_rd0, 4);
    chk("wd_addr1", m_rd1, 6);
    chk("wd_stage", m_stage, 1);
    bf_done = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      step();
      chk("wd_wait_busy",  m_busy, 1);
      chk("wd_wait_wr",    m_wr_en, 0);
      chk("wd_wait_error", m_error, 0);
    end
    step();
    chk("wd_error", m_error, 1);
    chk("wd_busy",  m_busy, 0);
    chk("wd_done",  m_done, 0);
    chk("wd_wr",    m_wr_en, 0);
    bf_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_idle_wr",    m_wr_en, 0);
      chk("wd_idle_done",  m_done, 0);
      chk("wd_idle_error", m_error, 1);
      chk("wd_idle_start", m_bf_start, 0);
    end
    start = 1'b1; step(); start = 1'b0;
    chk("wd_err_clr", m_error, 0);
    run_min(1'b0);
    chk("wd_rerun_error", m_error, 0);
    sel_wd = 1'b0;

    // Reset during WAIT of butterfly (2,3)
    do_reset();
    bf_done = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 57; c++) step();
    chk("rw_bf_start", m_bf_start, 1);
    chk("rw_addr0", m_rd0, 3);
    chk("rw_addr1", m_rd1, 7);
    chk("rw_tw",    m_tw, 6);
    chk("rw_stage", m_stage, 2);
    bf_done = 1'b0;
    step();
    step();
    chk("rw_wait_busy", m_busy, 1);
    rst = 1'b1;
    step();
    chk_zero("rw_rst");
    rst = 1'b0;
    bf_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_post_wr",   m_wr_en, 0);
      chk("rw_post_done", m_done, 0);
      chk("rw_post_busy", m_busy, 0);
    end
    start = 1'b1; step(); start = 1'b0;
    chk("rw_restart_addr0", m_rd0, 0);
    chk("rw_restart_addr1", m_rd1, 1);
    chk("rw_restart_stage", m_stage, 0);
    run_min(1'b0);

    // Start pulses during busy and during DONE are ignored
    step();
    start = 1'b1; step(); start = 1'b0;
    run_min(1'b1);
    step();
    start = 1'b0;
    chk("poke_idle_start", m_bf_start, 0);
    chk("poke_idle_busy",  m_busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("poke_quiet_start", m_bf_start, 0);
      chk("poke_quiet_done",  m_done, 0);
    end

    // Start held high: back-to-back transforms, done pulses 98 cycles apart
    start = 1'b1; step();
    run_min(1'b0);
    step();
    chk("held_gap_start", m_bf_start, 0);
    chk("held_gap_busy",  m_busy, 0);
    chk("held_gap_done",  m_done, 0);
    step();
    run_min(1'b0);
    start = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft16_stage_ctrl.md
# fft16_stage_ctrl

Sequencer for the 16-point radix-2 DIT FFT. It walks all log2(16)=4 stages × 8 butterflies, drives the shared `butterfly2` unit through a start/done handshake, and issues read/write addresses and a twiddle index for each butterfly. It sits between the sample RAM, which is loaded in bit-reversed order and is outside this block, and the butterfly datapath. A watchdog aborts the transform if the butterfly stops answering.

## Interface
- `LOG2N`, default 4: log2 of FFT points. Address width = LOG2N; twiddle index width = LOG2N-1.
- `BF_TIMEOUT`, default 255: maximum number of WAIT cycles without `i_bf_done` before the transform aborts. Range 1..255.

Ports:
- `i_clk`, input, 1: the single clock. Everything is rising-edge.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_start`, input, 1: request a transform. Sampled only in IDLE.
- `i_bf_done`, input, 1: butterfly result ready. Sampled only in WAIT.
- `o_bf_start`, output, 1: one-cycle pulse that launches the butterfly.
- `o_rd_addr0`, `o_rd_addr1`, output, LOG2N: RAM addresses of the two butterfly operands.
- `o_tw_idx`, output, LOG2N-1: twiddle ROM index k for W16^k.
- `o_wr_en`, output, 1: one-cycle write strobe for both results.
- `o_wr_addr0`, `o_wr_addr1`, output, LOG2N: write addresses. Always equal to the read addresses (in-place).
- `o_stage`, output, 2: current stage, 0..3.
- `o_busy`, output, 1: a transform is in progress.
- `o_done`, output, 1: one-cycle pulse when the transform completes.
- `o_error`, output, 1: sticky watchdog abort flag.

## Operation
- FSM states: IDLE, START, WAIT, WRITE, DONE. Internal counters: stage s (0..3), butterfly k (0..7), watchdog w (8 bits).
- IDLE -> START when `i_start`=1. Accepting a start clears s, k, w and `o_error`.
- START: `o_bf_start`=1 for exactly this cycle. Always goes to WAIT next. Any `i_bf_done` seen in START is ignored as stale.
- WAIT:
  - `i_bf_done`=1 -> WRITE.
  - Otherwise w increments. When w reaches BF_TIMEOUT -> IDLE, with `o_error` set and `o_busy`=0.
- WRITE: `o_wr_en`=1 for this cycle.
  - If s=3 and k=7 -> DONE.
  - Otherwise advance k. When k wraps 7->0, s increments. Then -> START.
- DONE: `o_done`=1 and `o_busy`=0 for one cycle, then -> IDLE.
- Address and twiddle generation, all from registered s and k:
  - half = 2^s, j = k mod half, g = k / half.
  - `o_rd_addr0` = g·2·half + j; `o_rd_addr1` = `o_rd_addr0` + half.
  - `o_tw_idx` = j << (3-s).
  - These outputs are stable from the START cycle through the WRITE cycle of each butterfly. They hold their last value in IDLE and DONE.
- `o_busy`=1 in START, WAIT and WRITE; 0 in all other states.
- `i_start` is ignored outside IDLE, including in DONE.

## Timing
- Reset: state IDLE. All outputs are 0, including the addresses, `o_tw_idx`, `o_stage` and `o_error`. Counters are 0.
- Reset in any state, mid-transform included, takes effect at the next edge. No `o_wr_en` or `o_done` is emitted after it.
- Let E0 be the edge that samples `i_start`=1 in IDLE. Counting cycles from there:
  - Cycle 1: `o_bf_start`=1, with addresses for (s=0, k=0) valid.
  - If `i_bf_done` is high in the first WAIT cycle (cycle 2), `o_wr_en` is high in cycle 3 and the next `o_bf_start` is in cycle 4.
  - Each butterfly costs 3 + d cycles, where d = extra WAIT cycles.
  - Minimum transform: 32 butterflies × 3 = 96 cycles, with `o_done` in cycle 97.
- Watchdog: w resets on entry to every WAIT. An abort happens after exactly BF_TIMEOUT consecutive WAIT cycles without done. `o_error` goes high the cycle after the abort edge and stays high until the next accepted start or reset.
- `i_bf_done` and the timeout limit in the same cycle: done wins and the FSM goes to WRITE.
- `i_start` held high continuously: a new transform is accepted in the IDLE cycle that follows DONE.

## Test plan
- Reset, then `i_start` pulse with `i_bf_done` tied to 1:
  - `o_bf_start` in cycles 1, 4, 7, …; `o_done` in cycle 97; `o_busy` high in cycles 1..96.
  - Exactly 32 `o_wr_en` pulses.
- Address check, logging (s,k) -> (addr0, addr1, tw):
  - (0,0) -> (0,1,0); (0,1) -> (2,3,0).
  - (1,1) -> (1,3,4).
  - (2,5) -> (9,13,2).
  - (3,7) -> (7,15,7).
- Variable latency: `i_bf_done` returns a random 1..20 cycles after each `o_bf_start`, and is also held high during START cycles. Required:
  - Stale done in START is ignored.
  - Addresses are unchanged from START through WRITE.
  - 32 writes in total and exactly one `o_done`.
- Watchdog with BF_TIMEOUT=10: `i_bf_done` never asserted on butterfly (1,2). Required:
  - Abort after 10 WAIT cycles.
  - `o_error`=1, `o_busy`=0, no `o_done`, no `o_wr_en` for that butterfly.
  - A following `i_start` clears `o_error` and completes normally.
- `i_rst` asserted during WAIT of (2,3): at the next edge all outputs are 0 and the state is IDLE. A later start begins at (0,0).
- `i_start` pulsed during busy and during DONE: ignored, with exactly one `o_done` per accepted start. `i_start` held high: back-to-back transforms with `o_done` 98 cycles apart.
